// File: rtl/mem_interface_unit.sv
// mem_interface_unit: multi-cycle memory access sequencer with alignment check and ack timeout.
module mem_interface_unit #(
  parameter int WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        I_or_D,
  input  logic        Mem_Write,
  input  logic        IR_Write,
  input  logic [31:0] PC,
  input  logic [31:0] ALU_Out,
  input  logic [31:0] Write_Data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] Data,
  output logic        mem_busy,
  output logic        mem_done,
  output logic        addr_err,
  output logic        timeout_err
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LIM = CW'(WAIT_MAX - 1);
  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;
  state_t r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_instr, r_data, w_sel;
  logic [CW-1:0] r_cnt;
  logic r_we, r_ir, r_addr_err, r_to;
  logic w_idle, w_acc, w_misal, w_start, w_timeout, w_load_done;
  assign w_idle = r_state == IDLE;
  assign w_acc = r_state == ACCESS;
  assign w_sel = I_or_D ? ALU_Out : PC;
  assign w_misal = w_idle && req_valid && w_sel[1:0] != 2'b00;
  assign w_start = w_idle && req_valid && w_sel[1:0] == 2'b00;
  // the cycle that would bring the no-ack count to WAIT_MAX aborts, unless ack wins
  assign w_timeout = w_acc && !mem_ack && r_cnt == LIM;
  assign w_load_done = w_acc && mem_ack && !r_we;
  always_comb begin
    w_next = w_idle ? (w_start ? ACCESS : IDLE) :
             w_acc ? (mem_ack ? COMPLETE : (w_timeout ? IDLE : ACCESS)) : IDLE;
    mem_req = w_acc;
    mem_busy = w_acc;
    mem_we = w_acc && r_we;
    mem_addr = w_acc ? r_addr : 32'd0;
    mem_wdata = w_acc ? r_wdata : 32'd0;
    mem_done = r_state == COMPLETE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_wdata <= '0;
      r_we <= 1'b0;
      r_ir <= 1'b0;
      r_cnt <= '0;
      r_instr <= '0;
      r_data <= '0;
      r_addr_err <= 1'b0;
      r_to <= 1'b0;
    end else begin
      r_state <= w_next;
      r_addr_err <= w_misal;
      r_to <= w_timeout;
      r_cnt <= (w_acc && !mem_ack && !w_timeout) ? r_cnt + 1'b1 : '0;
      if (w_start) begin
        r_addr <= w_sel;
        r_wdata <= Write_Data;
        r_we <= Mem_Write;
        r_ir <= IR_Write && !Mem_Write;
      end
      if (w_load_done) r_data <= mem_rdata;
      if (w_load_done && r_ir) r_instr <= mem_rdata;
    end
  end
  assign Instr = r_instr;
  assign Data = r_data;
  assign addr_err = r_addr_err;
  assign timeout_err = r_to;
endmodule

// File: doc/mem_interface_unit.md
MEM_INTERFACE_UNIT -- requirements
Module: mem_interface_unit

Interface
REQ-001 Parameter WAIT_MAX, default 16: maximum mem_req cycles allowed without mem_ack before the access is aborted.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (reset=0 resets on the next rising clk edge).
REQ-004 req_valid  input  1  the control unit requests one memory access this cycle.
REQ-005 I_or_D  input  1  address select: 0 = PC (fetch), 1 = ALU_Out (data).
REQ-006 Mem_Write  input  1  1 = store, 0 = load.
REQ-007 IR_Write  input  1  a load result is also captured into Instr.
REQ-008 PC  input  32  fetch address.
REQ-009 ALU_Out  input  32  data address.
REQ-010 Write_Data  input  32  store data (register B).
REQ-011 mem_req  output  1  memory request, held until acknowledged.
REQ-012 mem_we  output  1  memory write enable, valid while mem_req=1.
REQ-013 mem_addr  output  32  memory byte address, valid while mem_req=1.
REQ-014 mem_wdata  output  32  memory write data, valid while mem_req=1.
REQ-015 mem_ack  input  1  memory completes the access this cycle; mem_rdata is valid for a load.
REQ-016 mem_rdata  input  32  memory read data.
REQ-017 Instr  output  32  instruction register.
REQ-018 Data  output  32  memory data register.
REQ-019 mem_busy  output  1  stall to the control unit.
REQ-020 mem_done  output  1  one-cycle completion pulse.
REQ-021 addr_err  output  1  one-cycle misaligned-address pulse.
REQ-022 timeout_err  output  1  one-cycle timeout pulse.

Function
REQ-023 The FSM SHALL have three states, IDLE, ACCESS and COMPLETE, with all registers updated on the rising clk edge.
REQ-024 In IDLE with req_valid=1, the selected address SHALL be sel = I_or_D ? ALU_Out : PC.
REQ-025 In IDLE with req_valid=1 and sel[1:0]!=0: the unit SHALL pulse addr_err for the next cycle, start no memory access, and stay in IDLE.
REQ-026 In IDLE with req_valid=1 and an aligned address: the unit SHALL latch sel, Write_Data, Mem_Write and (IR_Write & ~Mem_Write), then go to ACCESS.
REQ-027 In ACCESS, mem_req SHALL be 1, and mem_addr, mem_wdata and mem_we SHALL hold the latched values, stable until the cycle mem_ack=1.
REQ-028 In ACCESS, on mem_ack=1 for a load, Data SHALL take mem_rdata, and Instr SHALL also take mem_rdata when the latched IR flag is 1; the FSM SHALL then go to COMPLETE.
REQ-029 A store SHALL never modify Instr or Data.
REQ-030 In ACCESS, a wait counter SHALL count cycles with mem_ack=0; when it reaches WAIT_MAX, the unit SHALL abort: go to IDLE, pulse timeout_err, leave Instr/Data unchanged.
REQ-031 mem_ack arriving in the same cycle the count reaches WAIT_MAX SHALL take priority; no timeout is signalled.
REQ-032 In COMPLETE, mem_done SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-033 req_valid SHALL be ignored outside IDLE.
REQ-034 mem_busy SHALL be 1 in ACCESS and 0 in IDLE and COMPLETE.
REQ-035 Minimum latency: req_valid in cycle 0; mem_req in cycle 1; mem_ack in cycle 1; Instr/Data valid in cycle 2; mem_done=1 in cycle 2.
REQ-036 mem_req and mem_we SHALL be 0 whenever the state is not ACCESS.
REQ-037 mem_addr and mem_wdata SHALL be 0 whenever the state is not ACCESS.

Reset
REQ-038 On reset=0 at a rising edge, the unit SHALL set: state IDLE, wait counter 0, Instr=0, Data=0, and all outputs 0.
REQ-039 Reset during ACCESS SHALL abort the transaction: mem_req=0 from the following cycle, and any mem_ack arriving in the reset cycle SHALL be ignored.

Verification
REQ-040 Fetch: PC=0x00000040, I_or_D=0, IR_Write=1, mem_ack on the first mem_req cycle with rdata=0x8C220004 -> mem_addr=0x40; Instr=Data=0x8C220004; mem_done pulse in cycle 2.
REQ-041 Store: ALU_Out=0x00000100, Write_Data=0xDEADBEEF, Mem_Write=1, IR_Write=1, ack after 3 wait cycles -> mem_we=1, mem_wdata=0xDEADBEEF held 4 cycles, mem_busy=1 for 4 cycles; Instr and Data unchanged.
REQ-042 Misaligned: I_or_D=1, ALU_Out=0x00000102 -> addr_err=1 for one cycle; mem_req never 1; state stays IDLE.
REQ-043 Timeout: WAIT_MAX=16, mem_ack held 0 -> timeout_err pulse after 16 request cycles; mem_req=0 afterwards; Instr/Data unchanged.
REQ-044 Reset mid-access: reset=0 in the second ACCESS cycle with mem_ack=1 -> Instr=Data=0 next cycle; no mem_done; mem_req=0.
REQ-045 Ack at limit: mem_ack in the same cycle the count reaches WAIT_MAX -> load completes; mem_done=1, timeout_err=0.
